// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit: shift-add multiply or restoring divide,
// one bit per cycle over WIDTH cycles, with signed-magnitude correction at the end.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 sign_a_q, sign_a_d;
  logic                 dbz_q, dbz_d;

  logic                 sgn_a, sgn_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH:0]     mul_ext;
  logic [WIDTH:0]       div_sh, div_diff;
  logic                 q_bit;
  logic [WIDTH-1:0]     div_rem, fix_quo, fix_rem;
  logic [2*WIDTH-1:0]   iter_nxt, fix_mul;

  // Magnitudes: the most-negative value maps onto itself, read as unsigned 2^(WIDTH-1).
  assign sgn_a = op_i[0] & opa_i[WIDTH-1];
  assign sgn_b = op_i[0] & opb_i[WIDTH-1];
  assign mag_a = sgn_a ? -opa_i : opa_i;
  assign mag_b = sgn_b ? -opb_i : opb_i;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign mul_ext  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:0]} : {1'b0, acc_q};

  // Partial remainder stays below the divisor, so WIDTH+1 bits hold the trial subtract.
  assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, b_q};
  assign q_bit    = ~div_diff[WIDTH];
  assign div_rem  = q_bit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];

  assign iter_nxt = is_div_q ? {div_rem, acc_q[WIDTH-2:0], q_bit} : mul_ext[2*WIDTH:1];
  assign fix_mul  = neg_q    ? -iter_nxt : iter_nxt;
  assign fix_quo  = neg_q    ? -iter_nxt[WIDTH-1:0] : iter_nxt[WIDTH-1:0];
  assign fix_rem  = sign_a_q ? -iter_nxt[2*WIDTH-1:WIDTH] : iter_nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    b_d      = b_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          is_div_d = op_i[1];
          neg_d    = sgn_a ^ sgn_b;
          sign_a_d = sgn_a;
          b_d      = mag_b;
          cnt_d    = CW'(WIDTH);
          if (op_i[1] && (opb_i == '0)) begin
            acc_d   = {opa_i, {WIDTH{1'b1}}};
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            acc_d   = is_div_q ? {fix_rem, fix_quo} : fix_mul;
            state_d = S_DONE;
          end else begin
            acc_d = iter_nxt;
          end
        end
      end
      S_DONE: begin
        // The finished result only becomes the held value if the pulse was not annulled.
        if (!annul_i) result_d = acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      b_q      <= b_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy_o        = (state_q == S_CALC);
  assign ready_o       = (state_q == S_DONE) && !annul_i;
  assign div_by_zero_o = ready_o && dbz_q;
  assign result_o      = ready_o ? acc_q : result_q;

endmodule

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the EX stage, replacing the fixed 32-bit divider and the separate multiplier with one shared datapath. It accepts one operation per start, computes a full double-width product or a quotient/remainder pair over WIDTH iterations, and signals completion with a one-cycle ready pulse. EX drives start and holds its stall request until that pulse, then writes HI/LO from `result_o`.

## Interface
- `WIDTH`, default 32: operand width; even, ≥ 4.
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `start_i`  in  1  request; sampled only in IDLE.
- `op_i`  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- `opa_i`  in  WIDTH  multiplicand / dividend; sampled with start.
- `opb_i`  in  WIDTH  multiplier / divisor; sampled with start.
- `annul_i`  in  1  abort the in-flight operation (flush).
- `busy_o`  out  1  high while in CALC.
- `ready_o`  out  1  one-cycle completion pulse.
- `result_o`  out  2*WIDTH  MUL: full product; DIV: {remainder, quotient}, so the upper half is HI and the lower half is LO.
- `div_by_zero_o`  out  1  high together with `ready_o` when a divide had divisor 0.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - `start_i` and not `annul_i`: latch op and operands, load iteration counter = WIDTH, go to CALC.
  - Exception: a divide with `opb_i == 0` goes straight to DONE.
- **Signed ops (01, 11)**
  - Operands are converted to magnitudes before iterating; signs are latched.
  - The magnitude of the most-negative value is 2^(WIDTH-1), held as unsigned in WIDTH bits.
- **MUL**
  - Shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Signed: negate the final product if sign(a) XOR sign(b).
- **DIV**
  - Restoring division, one quotient bit per cycle.
  - Signed: quotient negated if sign(a) XOR sign(b); remainder takes the sign of the dividend.
  - Most-negative ÷ −1: quotient = most-negative value (wraps), remainder = 0.
- **Divide by zero:** quotient = all ones, remainder = `opa_i` as given (unsigned-interpreted bits), `div_by_zero_o` = 1.
- **CALC:** decrement the counter each cycle; when it reaches 0, move to DONE.
  - Sign correction is applied on the CALC→DONE transition.
- **DONE:**
  - `ready_o` = 1 and `result_o` is valid.
  - Unconditionally return to IDLE next cycle; `start_i` in DONE is ignored.
  - EX deasserts `start_i` on the cycle it sees `ready_o`.
- **`result_o` hold:** holds its value from DONE until the next DONE.
  - It is not cleared on IDLE or on annul.
- **annul_i**
  - In CALC or DONE: go to IDLE on the next edge; no `ready_o` pulse.
  - In DONE this suppresses `ready_o` in the same cycle (combinational gate); `result_o` is unchanged from its prior value.
  - In IDLE together with `start_i`: annul wins, nothing is accepted.
- **Reset (`resetn` low, any time, including mid-operation):** state = IDLE, counter = 0, accumulators = 0.
  - All outputs read 0: `result_o`, `ready_o`, `busy_o`, `div_by_zero_o`.

## Timing
- Start accepted at edge 0 (in IDLE).
- CALC occupies cycles 1..WIDTH; `busy_o` is high for exactly WIDTH cycles.
- DONE at cycle WIDTH+1: `ready_o` is high for exactly that cycle (33 for WIDTH=32).
- Divide by zero: DONE at cycle 1, `busy_o` is never asserted.
- Back-to-back: the earliest next accept is the IDLE cycle after DONE.
  - Throughput is one op per WIDTH+2 cycles.
- `ready_o`, `busy_o` and `div_by_zero_o` are registered state decodes, gated only by `annul_i` as above.
- No combinational path from the operand inputs to any output.

## Test plan
- **MULTU** 0xFFFFFFFF × 0xFFFFFFFF, start at cycle 0 → `ready_o` only at cycle 33; `result_o` = 0xFFFFFFFE_00000001; `busy_o` high for cycles 1–32.
- **MULT** −3 × 7 → `result_o` = 0xFFFFFFFF_FFFFFFEB. **MULT** 0x80000000 × 0x80000000 → 0x40000000_00000000.
- **DIV** −7 ÷ 2 → `result_o` = {0xFFFFFFFF, 0xFFFFFFFD}. **DIV** 0x80000000 ÷ 0xFFFFFFFF → {0x00000000, 0x80000000}, `div_by_zero_o` = 0.
- **DIVU** 5 ÷ 0 → `ready_o` and `div_by_zero_o` at cycle 1; `result_o` = {0x00000005, 0xFFFFFFFF}; `busy_o` never high.
- **annul_i** pulsed at cycle 10 of a DIVU 100 ÷ 7 → IDLE at cycle 11, no `ready_o`, `result_o` keeps its previous value.
  - Then start DIVU 100 ÷ 7 → {2, 14} at cycle WIDTH+1.
- **Reset mid-operation:** `resetn` low asynchronously at cycle 5 of a MULT → all outputs 0 immediately.
  - After release, start DIV 9 ÷ −4 → {1, 0xFFFFFFFE}.
- **WIDTH=8 instance**
  - DIV 0x80 ÷ 0xFF → {0x00, 0x80} at cycle 9.
  - MULTU 0xFF × 0xFF → 0xFE01.
